// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, retiring
// STEP bits per CALC cycle. Division by zero and signed overflow are
// resolved at acceptance and skip the iteration entirely.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            valid_o,
  output logic            reg_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int NCYC  = XLEN / STEP;
  localparam int CNT_W = $clog2(NCYC + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sign1_q;
  logic              sign2_q;
  logic [XLEN-1:0]   hi_q;    // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;    // multiplier bits / dividend-quotient bits
  logic [XLEN-1:0]   opnd_q;  // multiplicand or divisor magnitude
  logic              valid_q;
  logic              reg_wen_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;

  // ---------------------------------------------------------------
  // Request decode (operates on the incoming operands in IDLE)
  // ---------------------------------------------------------------
  logic            in_is_div;
  logic            in_op1_signed;
  logic            in_op2_signed;
  logic            in_neg1;
  logic            in_neg2;
  logic [XLEN-1:0] in_abs1;
  logic [XLEN-1:0] in_abs2;
  logic            in_div_zero;
  logic            in_div_ovf;
  logic            in_special;
  logic [XLEN-1:0] in_special_res;
  logic            accept;

  assign in_is_div     = op_i[2];
  assign in_op1_signed = (op_i == OP_MULH) | (op_i == OP_MULHSU) |
                         (op_i == OP_DIV)  | (op_i == OP_REM);
  assign in_op2_signed = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
  assign in_neg1       = in_op1_signed & op1_i[XLEN-1];
  assign in_neg2       = in_op2_signed & op2_i[XLEN-1];
  // Negating the most negative value yields 2^(XLEN-1) read as unsigned.
  assign in_abs1       = in_neg1 ? (~op1_i + 1'b1) : op1_i;
  assign in_abs2       = in_neg2 ? (~op2_i + 1'b1) : op2_i;

  assign in_div_zero   = in_is_div & (op2_i == '0);
  assign in_div_ovf    = in_is_div & in_op2_signed &
                         (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
  assign in_special    = in_div_zero | in_div_ovf;

  // op_i[1] selects the remainder flavour among the divide ops.
  always_comb begin
    in_special_res = '0;
    if (in_div_zero) begin
      in_special_res = op_i[1] ? op1_i : '1;
    end else if (in_div_ovf) begin
      in_special_res = op_i[1] ? '0 : op1_i;
    end
  end

  assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

  // ---------------------------------------------------------------
  // Iteration datapath: STEP chained single-bit stages per cycle
  // ---------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      logic [XLEN-1:0] hi_in;
      logic [XLEN-1:0] lo_in;
      logic [XLEN-1:0] hi_out;
      logic [XLEN-1:0] lo_out;
      logic [XLEN:0]   add_sum;
      logic [XLEN:0]   sh_rem;
      logic [XLEN:0]   trial;

      if (gi == 0) begin : g_first
        assign hi_in = hi_q;
        assign lo_in = lo_q;
      end else begin : g_next
        assign hi_in = g_stage[gi-1].hi_out;
        assign lo_in = g_stage[gi-1].lo_out;
      end

      // Multiply: add multiplicand if the current multiplier bit is set,
      // then shift {carry, hi, lo} right by one.
      assign add_sum = {1'b0, hi_in} + ({1'b0, opnd_q} & {(XLEN+1){lo_in[0]}});
      // Divide: shift the next dividend bit into the remainder and try
      // subtracting the divisor; keep the difference when it is non-negative.
      assign sh_rem  = {hi_in, lo_in[XLEN-1]};
      assign trial   = sh_rem - {1'b0, opnd_q};

      assign hi_out = op_q[2] ? (trial[XLEN] ? sh_rem[XLEN-1:0] : trial[XLEN-1:0])
                              : add_sum[XLEN:1];
      assign lo_out = op_q[2] ? {lo_in[XLEN-2:0], ~trial[XLEN]}
                              : {add_sum[0], lo_in[XLEN-1:1]};
    end
  endgenerate

  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  assign hi_n     = g_stage[STEP-1].hi_out;
  assign lo_n     = g_stage[STEP-1].lo_out;
  assign prod_fix = (sign1_q ^ sign2_q) ? (~{hi_n, lo_n} + 1'b1) : {hi_n, lo_n};
  assign quo_fix  = (sign1_q ^ sign2_q) ? (~lo_n + 1'b1) : lo_n;
  assign rem_fix  = sign1_q ? (~hi_n + 1'b1) : hi_n;

  // Final result select applied on the last CALC cycle.
  always_comb begin
    calc_res = '0;
    case (op_q)
      OP_MUL:                        calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = quo_fix;
      OP_REM, OP_REMU:               calc_res = rem_fix;
      default:                       calc_res = '0;
    endcase
  end

  // Control FSM with registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_i;
            rd_q    <= rd_addr_i;
            sign1_q <= in_neg1;
            sign2_q <= in_neg2;
            if (in_special) begin
              state_q   <= S_DONE;
              valid_q   <= 1'b1;
              reg_wen_q <= (rd_addr_i != 5'd0);
              rd_addr_q <= rd_addr_i;
              rd_data_q <= in_special_res;
            end else begin
              state_q <= S_CALC;
              cnt_q   <= CNT_W'(NCYC);
              hi_q    <= '0;
              lo_q    <= in_is_div ? in_abs1 : in_abs2;
              opnd_q  <= in_is_div ? in_abs2 : in_abs1;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q   <= S_DONE;
              valid_q   <= 1'b1;
              reg_wen_q <= (rd_q != 5'd0);
              rd_addr_q <= rd_q;
              rd_data_q <= calc_res;
            end
          end
        end
        // DONE always returns to IDLE; a flush here changes nothing further.
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign hold_flag_o = accept | (state_q == S_CALC);
  assign valid_o     = valid_q;
  assign reg_wen_o   = reg_wen_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model (default XLEN=32, STEP=1).
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        hold_flag_o;
  logic        valid_o;
  logic        reg_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.XLEN(32), .STEP(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o),
    .valid_o     (valid_o),
    .reg_wen_o   (reg_wen_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ubs;
    logic signed [63:0] sp;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'b0, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin sp = sa * sb;  return sp[31:0];  end
      3'd1: begin sp = sa * sb;  return sp[63:32]; end
      3'd2: begin sp = sa * ubs; return sp[63:32]; end
      3'd3: begin up = ua * ub;  return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at cycle T and check latency, stall window and writeback.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    logic        special;
    int          exp_lat;
    int          k;
    int          holds;
    exp     = ref_model(op, a, b);
    special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = special ? 1 : 33;
    @(negedge clk);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
    #1;
    chk({tag, " hold_T"}, hold_flag_o, 1);
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 1;
    holds = 0;
    while (valid_o !== 1'b1 && k < 60) begin
      if (hold_flag_o) holds++;
      @(posedge clk); #1;
      k++;
    end
    $display("op=%0d a=%h b=%h rd=%0d -> data=%h wen=%0d latency=%0d",
             op, a, b, rd, rd_data_o, reg_wen_o, k);
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " data"}, rd_data_o, exp);
    chk({tag, " reg_wen"}, reg_wen_o, (rd != 0));
    chk({tag, " rd_addr"}, rd_addr_o, rd);
    chk({tag, " hold_done"}, hold_flag_o, 0);
    chk({tag, " hold_cycles"}, holds, exp_lat - 1);
    @(posedge clk); #1;
    chk({tag, " valid_after"}, valid_o, 0);
    chk({tag, " busy_after"}, busy_o, 0);
    chk({tag, " data_held"}, rd_data_o, exp);
  endtask

  initial begin
    int seen;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b1; start_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy_o, 0);
    chk("reset hold", hold_flag_o, 0);
    chk("reset valid", valid_o, 0);
    chk("reset wen", reg_wen_o, 0);
    chk("reset rd", rd_addr_o, 0);
    chk("reset data", rd_data_o, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul7xm3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, "mulh_min");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, "mulhu_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, "mulhsu");
    run_op(3'd5, 32'd100, 32'd7, 5'd5, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd6, "remu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, "rem_neg");
    run_op(3'd4, 32'd5, 32'd0, 5'd9, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd10, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "divu_big");

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end

    // Flush in CALC at T+10
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; op1_i = 32'd3; op2_i = 32'd9; rd_addr_i = 5'd14;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("flush at T+10 -> busy=%0d hold=%0d", busy_o, hold_flag_o);
    chk("flush busy", busy_o, 0);
    chk("flush hold", hold_flag_o, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("flush no_valid", seen, 0);

    // Start with flush in the same cycle is not accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; op1_i = 32'd5; op2_i = 32'd0;
    #1;
    chk("startflush hold", hold_flag_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    $display("start+flush -> busy=%0d valid=%0d", busy_o, valid_o);
    chk("startflush busy", busy_o, 0);
    chk("startflush valid", valid_o, 0);

    // Asynchronous reset mid-operation
    run_op(3'd0, 32'd3, 32'd5, 5'd15, "pre_reset");
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd16;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    $display("reset mid-op -> busy=%0d data=%h", busy_o, rd_data_o);
    chk("midrst busy", busy_o, 0);
    chk("midrst hold", hold_flag_o, 0);
    chk("midrst valid", valid_o, 0);
    chk("midrst wen", reg_wen_o, 0);
    chk("midrst rd", rd_addr_o, 0);
    chk("midrst data", rd_data_o, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 5'd0, "x0_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
